// File: rtl/snn_readout_pkg.sv
// Shared types for the SNN output readout: FSM state encoding and counts_flat slicing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package snn_readout_pkg;

    // Readout sequence: pulse network clear, count a window, argmax scan, hold result
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SCAN   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    // LSB position of channel ch inside a flattened vector of width-bit counters
    function automatic int unsigned flat_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sat_spike_counter.sv
// Per-channel saturating spike counter with a sticky saturation flag.
// Latency: count/ovf update on the edge that samples inc; clear wins over inc.
// Backpressure: none; an increment at full scale is dropped and recorded in ovf.
module sat_spike_counter #(
    parameter int COUNTER_SIZE = 8
)(
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    inc,
    output logic [COUNTER_SIZE-1:0] count,
    output logic                    ovf
);

    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = {COUNTER_SIZE{1'b1}};

    // Count up to full scale; further spikes only set the sticky overflow flag
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                count <= count + COUNTER_SIZE'(1);
            end
        end
    end

endmodule

// File: rtl/spike_count_classifier.sv
// SNN readout: per start, clears the network, counts spikes per channel over a window, argmax-scans the winner.
// Latency: start accepted at edge k -> snn_rst during the following cycle, result_valid at edge k+2+W+NUM_CHANNELS.
// Backpressure: result_valid/winner/winner_count/tie hold while result_ready=0; start is ignored until back in IDLE.
module spike_count_classifier
    import snn_readout_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int COUNTER_SIZE = 8,
    parameter  int WINDOW_WIDTH = 16,
    localparam int IDX_W        = $clog2(NUM_CHANNELS)
)(
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESETN,
    input  logic                                 start,
    input  logic [WINDOW_WIDTH-1:0]              window_len,
    input  logic [NUM_CHANNELS-1:0]              spike_in,
    output logic                                 snn_rst,
    output logic                                 busy,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic [IDX_W-1:0]                     winner,
    output logic [COUNTER_SIZE-1:0]              winner_count,
    output logic                                 tie,
    output logic [NUM_CHANNELS*COUNTER_SIZE-1:0] counts_flat,
    output logic [NUM_CHANNELS-1:0]              overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic                      accept;
    logic                      cnt_clr;
    logic [NUM_CHANNELS-1:0]   cnt_inc;
    logic [COUNTER_SIZE-1:0]   cnt [NUM_CHANNELS];
    logic [WINDOW_WIDTH-1:0]   win_cnt;
    logic [IDX_W-1:0]          scan_idx;
    logic [COUNTER_SIZE-1:0]   scan_cur;
    logic [COUNTER_SIZE-1:0]   run_max;
    logic [IDX_W-1:0]          run_idx;
    logic                      run_tie;
    logic                      result_valid_nxt;
    logic                      load_result;

    // start is only honoured from IDLE; everything else ignores it
    assign accept   = (state == ST_IDLE) && start;
    // Counters clear on reset and on every accepted start
    assign cnt_clr  = !S_AXI_ARESETN || accept;
    // spike_in only reaches the counters during the counting window
    assign cnt_inc  = (state == ST_COUNT) ? spike_in : '0;
    assign scan_cur = cnt[scan_idx];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        sat_spike_counter #(
            .COUNTER_SIZE (COUNTER_SIZE)
        ) u_cnt (
            .clk   (S_AXI_ACLK),
            .clr   (cnt_clr),
            .inc   (cnt_inc[i]),
            .count (cnt[i]),
            .ovf   (overflow[i])
        );
        assign counts_flat[flat_lsb(i, COUNTER_SIZE) +: COUNTER_SIZE] = cnt[i];
    end

    // State register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero-length window skips COUNT; SCAN visits every channel once
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = (win_cnt != '0) ? ST_COUNT : ST_SCAN;
            ST_COUNT:  if (win_cnt == WINDOW_WIDTH'(1)) state_nxt = ST_SCAN;
            ST_SCAN:   if (scan_idx == LAST_IDX) state_nxt = ST_RESULT;
            ST_RESULT: if (result_valid && result_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: the first RESULT cycle copies the scan outcome into the result registers,
    // and result_valid rises together with them so winner/count/tie are already stable
    always_comb begin
        snn_rst          = (state == ST_CLEAR);
        busy             = (state != ST_IDLE);
        load_result      = (state == ST_RESULT) && !result_valid;
        result_valid_nxt = (state == ST_RESULT) && !(result_valid && result_ready);
    end

    // result_valid is registered; it drops on the cycle after the handshake
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            result_valid <= 1'b0;
        end else begin
            result_valid <= result_valid_nxt;
        end
    end

    // Window down-counter: loaded on start, one tick per COUNT cycle
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            win_cnt <= '0;
        end else if (accept) begin
            win_cnt <= window_len;
        end else if (state == ST_COUNT) begin
            win_cnt <= win_cnt - WINDOW_WIDTH'(1);
        end
    end

    // Scan pointer walks channel 0..NUM_CHANNELS-1 and parks at 0 outside SCAN
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            scan_idx <= '0;
        end else if (state == ST_SCAN && scan_idx != LAST_IDX) begin
            scan_idx <= scan_idx + IDX_W'(1);
        end else begin
            scan_idx <= '0;
        end
    end

    // Running argmax: strictly greater replaces, equal flags a tie and keeps the lower index
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            run_max <= '0;
            run_idx <= '0;
            run_tie <= 1'b0;
        end else if (state == ST_SCAN) begin
            if (scan_idx == '0) begin
                run_max <= scan_cur;
                run_idx <= '0;
                run_tie <= 1'b0;
            end else if (scan_cur > run_max) begin
                run_max <= scan_cur;
                run_idx <= scan_idx;
                run_tie <= 1'b0;
            end else if (scan_cur == run_max) begin
                run_tie <= 1'b1;
            end
        end
    end

    // Result registers: cleared on start, loaded once per classification, held in IDLE
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || accept) begin
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else if (load_result) begin
            winner       <= run_idx;
            winner_count <= run_max;
            tie          <= run_tie;
        end
    end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench for spike_count_classifier: 8-bit and 4-bit counter instances share stimulus.
// Latency: n/a (testbench).
// Backpressure: result_ready is held low for varying stretches to exercise result hold.
module tb_spike_count_classifier;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] window_len;
    logic [3:0]  spike_in;
    logic        result_ready;

    logic        snn_rst8, busy8, rv8, tie8;
    logic [1:0]  win8;
    logic [7:0]  wc8;
    logic [31:0] cf8;
    logic [3:0]  ov8;

    logic        snn_rst4, busy4, rv4, tie4;
    logic [1:0]  win4;
    logic [3:0]  wc4;
    logic [15:0] cf4;
    logic [3:0]  ov4;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  pat[$];
    logic [31:0] e_flat8, e_ov8, e_w8, e_wc8, e_t8;
    logic [31:0] e_flat4, e_ov4, e_w4, e_wc4, e_t4;

    always #5 clk = ~clk;

    spike_count_classifier #(.NUM_CHANNELS(4), .COUNTER_SIZE(8), .WINDOW_WIDTH(16)) dut8 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .window_len(window_len),
        .spike_in(spike_in), .snn_rst(snn_rst8), .busy(busy8), .result_valid(rv8),
        .result_ready(result_ready), .winner(win8), .winner_count(wc8), .tie(tie8),
        .counts_flat(cf8), .overflow(ov8)
    );

    spike_count_classifier #(.NUM_CHANNELS(4), .COUNTER_SIZE(4), .WINDOW_WIDTH(16)) dut4 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .window_len(window_len),
        .spike_in(spike_in), .snn_rst(snn_rst4), .busy(busy4), .result_valid(rv4),
        .result_ready(result_ready), .winner(win4), .winner_count(wc4), .tie(tie4),
        .counts_flat(cf4), .overflow(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum spikes per channel with saturation, then pick the largest count
    task automatic model(input int cs, output logic [31:0] flat, output logic [31:0] ov,
                         output logic [31:0] win, output logic [31:0] wc, output logic [31:0] tie);
        int c[NCH];
        int cap;
        int best;
        cap  = (1 << cs) - 1;
        flat = '0;
        ov   = '0;
        tie  = '0;
        for (int i = 0; i < NCH; i++) c[i] = 0;
        foreach (pat[t]) begin
            for (int i = 0; i < NCH; i++) begin
                if (pat[t][i]) begin
                    if (c[i] == cap) ov[i] = 1'b1;
                    else c[i] = c[i] + 1;
                end
            end
        end
        best = 0;
        for (int i = 0; i < NCH; i++) if (c[i] > c[best]) best = i;
        for (int i = 0; i < NCH; i++) if (i != best && c[i] == c[best]) tie = 32'd1;
        for (int i = 0; i < NCH; i++) flat = flat | (32'(c[i]) << (i * cs));
        win = 32'(best);
        wc  = 32'(c[best]);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cnt8"}, cf8, e_flat8);
        chk({tag, "_ovf8"}, 32'(ov8), e_ov8);
        chk({tag, "_win8"}, 32'(win8), e_w8);
        chk({tag, "_wc8"},  32'(wc8), e_wc8);
        chk({tag, "_tie8"}, 32'(tie8), e_t8);
        chk({tag, "_cnt4"}, 32'(cf4), e_flat4);
        chk({tag, "_ovf4"}, 32'(ov4), e_ov4);
        chk({tag, "_win4"}, 32'(win4), e_w4);
        chk({tag, "_wc4"},  32'(wc4), e_wc4);
        chk({tag, "_tie4"}, 32'(tie4), e_t4);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cnt8"}, cf8, 32'd0);
        chk({tag, "_ovf8"}, 32'(ov8), 32'd0);
        chk({tag, "_win8"}, 32'(win8), 32'd0);
        chk({tag, "_wc8"},  32'(wc8), 32'd0);
        chk({tag, "_tie8"}, 32'(tie8), 32'd0);
        chk({tag, "_rst8"}, 32'(snn_rst8), 32'd0);
        chk({tag, "_busy8"}, 32'(busy8), 32'd0);
        chk({tag, "_rv8"},  32'(rv8), 32'd0);
        chk({tag, "_cnt4"}, 32'(cf4), 32'd0);
        chk({tag, "_busy4"}, 32'(busy4), 32'd0);
        chk({tag, "_rv4"},  32'(rv4), 32'd0);
    endtask

    // One classification: mode selects the spike pattern, hold = ready-low cycles in RESULT
    task automatic run_txn(input int w, input int mode, input int hold, input bit poke);
        int       prob[NCH];
        int       c;
        int       rv_at;
        int       rst_cnt;
        logic [3:0] p;
        for (int i = 0; i < NCH; i++) prob[i] = int'($urandom_range(0, 100));
        pat.delete();
        for (int t = 0; t < w; t++) begin
            case (mode)
                1: p = 4'b0100 | ((t % 2 == 0) ? 4'b0001 : 4'b0000);
                2: p = 4'b1010;
                3: p = 4'b0001;
                default: begin
                    for (int i = 0; i < NCH; i++) p[i] = (int'($urandom_range(0, 99)) < prob[i]);
                end
            endcase
            pat.push_back(p);
        end
        model(8, e_flat8, e_ov8, e_w8, e_wc8, e_t8);
        model(4, e_flat4, e_ov4, e_w4, e_wc4, e_t4);

        chk("idle_busy", 32'(busy8), 32'd0);
        window_len = 16'(w);
        start      = 1'b1;
        spike_in   = 4'($urandom);
        @(posedge clk); #1;
        start      = 1'b0;
        window_len = 16'($urandom);
        c       = 0;
        rv_at   = -1;
        rst_cnt = 0;
        while (c < 400) begin
            if (c >= 1 && c <= w) spike_in = pat[c - 1];
            else spike_in = 4'($urandom);
            @(negedge clk);
            if (snn_rst8) rst_cnt++;
            if (c == 0) begin
                chk("clear_rst", 32'(snn_rst8), 32'd1);
                chk("clear_busy", 32'(busy8), 32'd1);
                chk("clear_cnt", cf8, 32'd0);
                chk("clear_win", {29'd0, win8, tie8}, 32'd0);
                chk("clear_wc", 32'(wc8), 32'd0);
            end
            if (rv8) begin
                rv_at = c;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        chk("rv_latency", 32'(rv_at), 32'(w + NCH + 2));
        chk("rv_narrow", 32'(rv4), 32'd1);
        chk("snn_rst_pulses", 32'(rst_cnt), 32'd1);
        check_all("res");

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            spike_in = 4'($urandom);
            if (poke && h == 2) begin
                start      = 1'b1;
                window_len = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("hold_rv", 32'(rv8), 32'd1);
            chk("hold_win", 32'(win8), e_w8);
            chk("hold_wc", 32'(wc8), e_wc8);
            chk("hold_tie", 32'(tie8), e_t8);
        end
        @(posedge clk); #1;
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        chk("hs_rv", 32'(rv8), 32'd1);
        @(posedge clk); #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk("post_rv", 32'(rv8), 32'd0);
        chk("post_busy", 32'(busy8), 32'd0);
        check_all("idle");
    endtask

    initial begin
        int seen_rv;
        rst_n        = 1'b0;
        start        = 1'b1;
        window_len   = 16'd5;
        spike_in     = 4'hF;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_idle_busy", 32'(busy8), 32'd0);

        run_txn(10, 1, 0, 1'b0);
        run_txn(6, 2, 0, 1'b0);
        run_txn(20, 3, 0, 1'b0);
        run_txn(7, 0, 8, 1'b1);
        run_txn(0, 0, 0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            run_txn(int'($urandom_range(1, 40)), 0, int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Abort in the middle of counting
        window_len = 16'd30;
        start      = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        spike_in = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        seen_rv = 0;
        repeat (50) begin
            @(negedge clk);
            if (rv8 || rv4) seen_rv = 1;
        end
        chk("midrst_no_result", 32'(seen_rv), 32'd0);
        chk("midrst_busy", 32'(busy8), 32'd0);

        run_txn(5, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
